assoc_tag_store: RTL and testbench

ASSOC_TAG_STORE -- requirements
Module: assoc_tag_store

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/assoc_lru_set.sv | 52 +++++
 rtl/assoc_tag_store.sv | 242 ++++++++++++++++++++++++
 tb/tb_assoc_tag_store.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the associative tag store: data word, request opcode,
// controller state and the opcode decode used at request capture.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_WRITE  = 2'd1,
        OP_FILL   = 2'd2
    } store_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_FSCAN,
        ST_FEMIT,
        ST_FDONE
    } state_t;

    // Opcode 3 is reserved and behaves exactly like a lookup
    function automatic store_op_t decode_op(input logic [1:0] op);
        case (op)
            2'd1:    return OP_WRITE;
            2'd2:    return OP_FILL;
            default: return OP_LOOKUP;
        endcase
    endfunction

endpackage

// File: rtl/assoc_lru_set.sv
// Age-based LRU for one set: computes the ages after an access and picks
// the replacement victim (first invalid way, otherwise the oldest way).
module assoc_lru_set
    import cpu_types_pkg::*;
#(
    parameter int NWAYS = 2,
    parameter int WAY_W = 1
) (
    input  logic [NWAYS*WAY_W-1:0] ages,
    input  logic [NWAYS-1:0]       valid,
    input  logic [WAY_W-1:0]       acc_way,
    output logic [NWAYS*WAY_W-1:0] ages_upd,
    output logic [WAY_W-1:0]       vic_way
);

    logic [WAY_W-1:0] acc_age;
    logic             found;

    assign acc_age = ages[acc_way*WAY_W +: WAY_W];

    // Younger-than-accessed ways age by one, the accessed way becomes youngest
    always_comb begin
        ages_upd = ages;
        for (int w = 0; w < NWAYS; w++) begin
            if (w == int'(acc_way)) begin
                ages_upd[w*WAY_W +: WAY_W] = '0;
            end else if (ages[w*WAY_W +: WAY_W] < acc_age) begin
                ages_upd[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + 1'b1;
            end
        end
    end

    // Descending scan leaves the lowest invalid way; fall back to the oldest
    always_comb begin
        vic_way = '0;
        found   = 1'b0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                vic_way = WAY_W'(w);
                found   = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (ages[w*WAY_W +: WAY_W] == WAY_W'(NWAYS - 1)) begin
                    vic_way = WAY_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/assoc_tag_store.sv
// Set-associative tag/data store with LRU replacement and a dirty-line
// write-back walk. Optional hit/miss counters under macro ASSOC_STATS_EN.
module assoc_tag_store
    import cpu_types_pkg::*;
#(
    parameter  int NWAYS  = 2,
    parameter  int NSETS  = 8,
    parameter  int WPB    = 2,
    localparam int WAY_W  = $clog2(NWAYS),
    localparam int IDX_W  = $clog2(NSETS),
    localparam int WOFF_W = $clog2(WPB),
    localparam int TAG_W  = 32 - 2 - WOFF_W - IDX_W,
    localparam int BLK_W  = 32 * WPB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  word_t            req_addr,
    input  word_t            req_wdat,
    input  logic [BLK_W-1:0] fill_blk,
    input  logic             fill_dirty,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output word_t            rsp_rdat,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_vic_valid,
    output logic             rsp_vic_dirty,
    output logic [TAG_W-1:0] rsp_vic_tag,
    output logic [BLK_W-1:0] rsp_vic_blk,
    input  logic             flush_req,
    output logic             flush_valid,
    input  logic             flush_ready,
    output logic [TAG_W-1:0] flush_tag,
    output logic [IDX_W-1:0] flush_idx,
    output logic [BLK_W-1:0] flush_blk,
    output logic             flush_done
`ifdef ASSOC_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    localparam int WOFF_WS = (WOFF_W > 0) ? WOFF_W : 1;

    state_t state, nstate;

    // Captured request
    store_op_t        op_p0;
    word_t            addr_p0;
    word_t            wdat_p0;
    logic [BLK_W-1:0] fblk_p0;
    logic             fdirty_p0;

    // Storage
    logic [TAG_W-1:0]       tag_q   [NSETS][NWAYS];
    logic [BLK_W-1:0]       data_q  [NSETS][NWAYS];
    logic [NWAYS-1:0]       valid_q [NSETS];
    logic [NWAYS-1:0]       dirty_q [NSETS];
    logic [NWAYS*WAY_W-1:0] age_q   [NSETS];

    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       rtag;
    logic [WOFF_WS-1:0]     woff;
    logic                   hit, vic_live, commit, flush_step, flush_last;
    logic [WAY_W-1:0]       hit_way, vic_way, acc_way, fway;
    logic [IDX_W-1:0]       fset;
    logic [NWAYS*WAY_W-1:0] ages_upd;
    logic [BLK_W-1:0]       hit_blk, vic_blk, wr_blk;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, addr_p0[1:0]};
    assign idx  = addr_p0[2+WOFF_W +: IDX_W];
    assign rtag = addr_p0[31 -: TAG_W];
    assign woff = (WPB > 1) ? addr_p0[2 +: WOFF_WS] : '0;

    function automatic logic [NWAYS*WAY_W-1:0] age_init();
        logic [NWAYS*WAY_W-1:0] a;
        for (int w = 0; w < NWAYS; w++) a[w*WAY_W +: WAY_W] = WAY_W'(w);
        return a;
    endfunction

    // Tag compare across the ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == rtag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign acc_way  = hit ? hit_way : vic_way;
    assign hit_blk  = data_q[idx][hit_way];
    assign vic_blk  = data_q[idx][vic_way];
    assign vic_live = (op_p0 == OP_FILL) && !hit && valid_q[idx][vic_way];

    // Block image for a write hit: one word replaced
    always_comb begin
        wr_blk                  = hit_blk;
        wr_blk[woff*32 +: 32]   = wdat_p0;
    end

    assoc_lru_set #(.NWAYS(NWAYS), .WAY_W(WAY_W)) u_lru (
        .ages     (age_q[idx]),
        .valid    (valid_q[idx]),
        .acc_way  (acc_way),
        .ages_upd (ages_upd),
        .vic_way  (vic_way)
    );

    assign flush_last = (fset == IDX_W'(NSETS - 1)) && (fway == WAY_W'(NWAYS - 1));

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    // Next state and handshake outputs
    always_comb begin
        nstate      = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        flush_valid = 1'b0;
        flush_done  = 1'b0;
        flush_step  = 1'b0;
        commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (flush_req)      nstate = ST_FSCAN;
                else if (req_valid) nstate = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                commit    = 1'b1;
                nstate    = ST_IDLE;
            end
            ST_FSCAN: begin
                if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
                    nstate = ST_FEMIT;
                end else begin
                    flush_step = 1'b1;
                    nstate     = flush_last ? ST_FDONE : ST_FSCAN;
                end
            end
            ST_FEMIT: begin
                flush_valid = 1'b1;
                if (flush_ready) begin
                    flush_step = 1'b1;
                    nstate     = flush_last ? ST_FDONE : ST_FSCAN;
                end
            end
            ST_FDONE: begin
                flush_done = 1'b1;
                nstate     = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    // Walk position, way-minor; parked at (0,0) while idle
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) begin
            fset <= '0;
            fway <= '0;
        end else if (flush_step) begin
            if (fway == WAY_W'(NWAYS - 1)) begin
                fway <= '0;
                fset <= fset + 1'b1;
            end else begin
                fway <= fway + 1'b1;
            end
        end
    end

    // Request capture and tag/data writes; contents survive reset
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && !flush_req && req_valid) begin
            op_p0     <= decode_op(req_op);
            addr_p0   <= req_addr;
            wdat_p0   <= req_wdat;
            fblk_p0   <= fill_blk;
            fdirty_p0 <= fill_dirty;
        end
        if (commit && op_p0 == OP_WRITE && hit) data_q[idx][hit_way] <= wr_blk;
        if (commit && op_p0 == OP_FILL) begin
            tag_q[idx][acc_way]  <= rtag;
            data_q[idx][acc_way] <= fblk_p0;
        end
    end

    // Valid, dirty and age state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                age_q[s]   <= age_init();
            end
        end else begin
            if (commit && (hit || op_p0 == OP_FILL)) age_q[idx] <= ages_upd;
            if (commit && op_p0 == OP_WRITE && hit) dirty_q[idx][hit_way] <= 1'b1;
            if (commit && op_p0 == OP_FILL) begin
                valid_q[idx][acc_way] <= 1'b1;
                dirty_q[idx][acc_way] <= fdirty_p0;
            end
            if (state == ST_FEMIT && flush_ready) dirty_q[fset][fway] <= 1'b0;
        end
    end

    assign rsp_hit       = rsp_valid & hit;
    assign rsp_way       = rsp_valid ? acc_way : '0;
    assign rsp_rdat      = (rsp_valid && hit && op_p0 == OP_LOOKUP) ? hit_blk[woff*32 +: 32] : '0;
    assign rsp_vic_valid = rsp_valid & vic_live;
    assign rsp_vic_dirty = rsp_vic_valid & dirty_q[idx][vic_way];
    assign rsp_vic_tag   = rsp_vic_valid ? tag_q[idx][vic_way] : '0;
    assign rsp_vic_blk   = rsp_vic_valid ? vic_blk : '0;

    assign flush_tag = flush_valid ? tag_q[fset][fway]  : '0;
    assign flush_idx = flush_valid ? fset               : '0;
    assign flush_blk = flush_valid ? data_q[fset][fway] : '0;

`ifdef ASSOC_STATS_EN
    // Lookup/write responses counted by outcome; fills are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (commit && op_p0 != OP_FILL) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_tag_store.sv
// Randomized bench for assoc_tag_store against a per-set MRU-list model.
module tb_assoc_tag_store;

    localparam int NWAYS  = 2;
    localparam int NSETS  = 8;
    localparam int WPB    = 2;
    localparam int WAY_W  = $clog2(NWAYS);
    localparam int IDX_W  = $clog2(NSETS);
    localparam int WOFF_W = $clog2(WPB);
    localparam int TAG_W  = 32 - 2 - WOFF_W - IDX_W;
    localparam int BLK_W  = 32 * WPB;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, fill_dirty;
    logic [1:0]       req_op;
    logic [31:0]      req_addr, req_wdat, rsp_rdat;
    logic [BLK_W-1:0] fill_blk, rsp_vic_blk, flush_blk;
    logic             rsp_valid, rsp_hit, rsp_vic_valid, rsp_vic_dirty;
    logic [WAY_W-1:0] rsp_way;
    logic [TAG_W-1:0] rsp_vic_tag, flush_tag;
    logic             flush_req, flush_valid, flush_ready, flush_done;
    logic [IDX_W-1:0] flush_idx;
`ifdef ASSOC_STATS_EN
    logic [31:0]      hit_cnt, miss_cnt;
`endif

    assoc_tag_store #(.NWAYS(NWAYS), .NSETS(NSETS), .WPB(WPB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdat(req_wdat), .fill_blk(fill_blk), .fill_dirty(fill_dirty),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_rdat(rsp_rdat), .rsp_way(rsp_way),
        .rsp_vic_valid(rsp_vic_valid), .rsp_vic_dirty(rsp_vic_dirty),
        .rsp_vic_tag(rsp_vic_tag), .rsp_vic_blk(rsp_vic_blk),
        .flush_req(flush_req), .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_tag(flush_tag), .flush_idx(flush_idx), .flush_blk(flush_blk), .flush_done(flush_done)
`ifdef ASSOC_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: order[s][0] is most recently used
    bit               m_valid [NSETS][NWAYS];
    bit               m_dirty [NSETS][NWAYS];
    logic [TAG_W-1:0] m_tag   [NSETS][NWAYS];
    logic [BLK_W-1:0] m_blk   [NSETS][NWAYS];
    int               m_order [NSETS][NWAYS];
    int               m_hits, m_miss;

    logic             last_hit, last_vv;
    logic [31:0]      last_rdat;
    logic [WAY_W-1:0] last_way;
    logic [TAG_W-1:0] last_vtag;
    logic [BLK_W-1:0] last_fblk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NWAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        m_hits = 0;
        m_miss = 0;
    endfunction

    function automatic void touch(int s, int w);
        int p = 0;
        for (int i = 0; i < NWAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endfunction

    function automatic logic [31:0] mk_addr(int tg, int s, int wo);
        return (32'(tg) << (32 - TAG_W)) | (32'(s) << (2 + WOFF_W)) | (32'(wo) << 2)
               | 32'($urandom_range(3, 0));
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [BLK_W-1:0] blk, input logic fd);
        int s, wo, hw, vw, eop, ew;
        bit hit, evv, evd;
        logic [TAG_W-1:0] tg, evt;
        logic [31:0] erd;
        logic [BLK_W-1:0] evb;
        s   = int'((addr >> (2 + WOFF_W)) % NSETS);
        wo  = int'((addr >> 2) % WPB);
        tg  = addr[31 -: TAG_W];
        eop = (op == 2'd1) ? 1 : (op == 2'd2) ? 2 : 0;
        hit = 0; hw = 0; vw = -1;
        for (int w = 0; w < NWAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tg) begin hit = 1; hw = w; end
        for (int w = NWAYS - 1; w >= 0; w--) if (!m_valid[s][w]) vw = w;
        if (vw < 0) vw = m_order[s][NWAYS-1];
        ew  = hit ? hw : vw;
        erd = (eop == 0 && hit) ? m_blk[s][hw][32*wo +: 32] : 32'd0;
        evv = (eop == 2) && !hit && m_valid[s][vw];
        evd = evv && m_dirty[s][vw];
        evt = evv ? m_tag[s][vw] : '0;
        evb = evv ? m_blk[s][vw] : '0;

        chk("req_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdat = wd;
        fill_blk = blk; fill_dirty = fd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_hit", rsp_hit, hit);
        chk("rsp_way", rsp_way, ew);
        chk("rsp_rdat", rsp_rdat, erd);
        chk("rsp_vic_valid", rsp_vic_valid, evv);
        chk("rsp_vic_dirty", rsp_vic_dirty, evd);
        chk("rsp_vic_tag", rsp_vic_tag, evt);
        chk("rsp_vic_blk", rsp_vic_blk, evb);
        last_hit = rsp_hit; last_way = rsp_way; last_rdat = rsp_rdat;
        last_vv = rsp_vic_valid; last_vtag = rsp_vic_tag;

        if (eop == 0 && hit) touch(s, hw);
        if (eop == 1 && hit) begin
            m_blk[s][hw][32*wo +: 32] = wd;
            m_dirty[s][hw] = 1'b1;
            touch(s, hw);
        end
        if (eop == 2) begin
            m_tag[s][ew] = tg; m_blk[s][ew] = blk;
            m_valid[s][ew] = 1'b1; m_dirty[s][ew] = fd;
            touch(s, ew);
        end
        if (eop != 2) begin
            if (hit) m_hits++; else m_miss++;
        end
        @(posedge clk); #1;
        chk("rsp_pulse", rsp_valid, 0);
    endtask

    task automatic do_flush(input int dlo, input int dhi);
        int q[$];
        int cyc, s, w, d;
        for (int i = 0; i < NSETS*NWAYS; i++)
            if (m_valid[i/NWAYS][i%NWAYS] && m_dirty[i/NWAYS][i%NWAYS]) q.push_back(i);
        chk("flush_idle", req_ready, 1);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        chk("flush_busy", req_ready, 0);
        chk("flush_no_rsp", rsp_valid, 0);
        foreach (q[k]) begin
            s = q[k] / NWAYS; w = q[k] % NWAYS;
            cyc = 0;
            while (!flush_valid && !flush_done && cyc < NSETS*NWAYS + 4) begin
                @(posedge clk); #1; cyc++;
            end
            chk("flush_valid", flush_valid, 1);
            if (flush_valid !== 1'b1) break;
            d = $urandom_range(dhi, dlo);
            for (int i = 0; i <= d; i++) begin
                chk("flush_hold", flush_valid, 1);
                chk("flush_idx", flush_idx, s);
                chk("flush_tag", flush_tag, m_tag[s][w]);
                chk("flush_blk", flush_blk, m_blk[s][w]);
                last_fblk = flush_blk;
                if (i < d) begin @(posedge clk); #1; end
            end
            flush_ready = 1'b1;
            @(posedge clk); #1;
            flush_ready = 1'b0;
            m_dirty[s][w] = 1'b0;
        end
        cyc = 0;
        while (!flush_done && !flush_valid && cyc < NSETS*NWAYS + 4) begin
            @(posedge clk); #1; cyc++;
        end
        chk("flush_done", flush_done, 1);
        @(posedge clk); #1;
        chk("flush_done_pulse", flush_done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int cyc, r;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdat = '0;
        fill_blk = '0; fill_dirty = 1'b0; flush_req = 1'b0; flush_ready = 1'b0;
        last_fblk = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_flush_valid", flush_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_rsp_rdat", rsp_rdat, 0);
        chk("idle_rsp_hit", rsp_hit, 0);
`ifdef ASSOC_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
`endif

        // Directed: cold miss, fill, read back, write, flush, eviction
        do_req(2'd0, 32'h40, 32'd0, '0, 1'b0);
        chk("cold_hit", last_hit, 0);
        chk("cold_way", last_way, 0);
        chk("cold_vic", last_vv, 0);
        do_req(2'd2, 32'h40, 32'd0, {32'hB, 32'hA}, 1'b0);
        do_req(2'd0, 32'h44, 32'd0, '0, 1'b0);
        chk("rd_hit", last_hit, 1);
        chk("rd_way", last_way, 0);
        chk("rd_word1", last_rdat, 32'hB);
        do_req(2'd1, 32'h40, 32'h55, '0, 1'b0);
        chk("wr_hit", last_hit, 1);
        do_flush(3, 3);
        chk("flush_word0", last_fblk[31:0], 32'h55);
        do_req(2'd2, 32'h80, 32'd0, {32'h2, 32'h1}, 1'b0);
        do_req(2'd2, 32'hC0, 32'd0, {32'h4, 32'h3}, 1'b0);
        chk("evict_vv", last_vv, 1);
        chk("evict_tag", last_vtag, 1);

        // Flush and request offered together: flush first, request afterwards
        do_req(2'd1, 32'h84, 32'h77, '0, 1'b0);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h84;
        do_flush(0, 2);
        do_req(2'd0, 32'h84, 32'd0, '0, 1'b0);
        chk("after_flush_rd", last_rdat, 32'h77);

        // Randomized traffic over a small tag/set pool so hits and evictions occur
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99, 0);
            if (r < 4) begin
                do_flush(0, 2);
            end else begin
                a = mk_addr($urandom_range(3, 1), $urandom_range(3, 0), $urandom_range(WPB-1, 0));
                do_req(2'($urandom_range(3, 0)), a, $urandom, {$urandom, $urandom},
                       1'($urandom_range(1, 0)));
            end
        end
`ifdef ASSOC_STATS_EN
        chk("rand_hit_cnt", hit_cnt, m_hits);
        chk("rand_miss_cnt", miss_cnt, m_miss);
`endif

        // Reset in the middle of a flush abandons it silently
        a = mk_addr(5, 2, 0);
        do_req(2'd2, a, 32'd0, {32'h9, 32'h8}, 1'b1);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        cyc = 0;
        while (!flush_valid && cyc < NSETS*NWAYS + 4) begin @(posedge clk); #1; cyc++; end
        chk("rstflush_valid", flush_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rstflush_idle", req_ready, 1);
        chk("rstflush_fv", flush_valid, 0);
        repeat (3) begin
            chk("rstflush_no_done", flush_done, 0);
            @(posedge clk); #1;
        end

        // Two misses then three hits
        do_req(2'd0, a, 32'd0, '0, 1'b0);
        chk("post_rst_miss", last_hit, 0);
        do_req(2'd1, a, 32'h1, '0, 1'b0);
        do_req(2'd2, a, 32'd0, {32'h6, 32'h5}, 1'b0);
        do_req(2'd0, a, 32'd0, '0, 1'b0);
        do_req(2'd0, a | 32'h4, 32'd0, '0, 1'b0);
        do_req(2'd1, a, 32'h9, '0, 1'b0);
        chk("stat_seq_hit", last_hit, 1);
`ifdef ASSOC_STATS_EN
        chk("stat_hit_cnt", hit_cnt, 3);
        chk("stat_miss_cnt", miss_cnt, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
